// File: rtl/dot_seq_pkg.sv
// Shared types, widths and helpers for the dot_seq sequencer.
// The optional clamping helper is used only when DOT_SEQ_SAT_EN is defined.
package dot_seq_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 26;
    localparam int LEN_W  = 8;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 26'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -26'sd32768;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_DRAIN  = 3'd3,
        S_LATCH  = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    typedef struct packed {
        logic             sat;
        logic [ACC_W-1:0] data;
    } sat_res_t;

    function automatic sat_res_t sat_clamp(input logic signed [ACC_W-1:0] v);
        sat_res_t r;
        if (v > SAT_MAX) begin
            r.sat  = 1'b1;
            r.data = SAT_MAX;
        end else if (v < SAT_MIN) begin
            r.sat  = 1'b1;
            r.data = SAT_MIN;
        end else begin
            r.sat  = 1'b0;
            r.data = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_seq.sv
// Dot-product sequencer: streams operand pairs into an external MAC and returns its sum.
// Optional feature macro: DOT_SEQ_SAT_EN clamps the result to the signed 16-bit range.
import dot_seq_pkg::*;

module dot_seq (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic              ab_valid,
    output logic              ab_ready,
    output logic [DATA_W-1:0] mac_in1,
    output logic [DATA_W-1:0] mac_in2,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_sat,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_a_q;
    logic [DATA_W-1:0]   r_b_q;
    logic [ACC_W-1:0]    r_res_data;
    logic                w_accept;
    logic                w_last;
    logic                w_ab_ready;
    logic                w_mac_clr;
    logic                w_res_valid;
    logic                w_busy;

    assign w_accept  = ab_valid && (r_state == S_ACCUM);
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_last    = (w_cnt_nxt == r_len);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (r_len != 8'd0) begin
                    w_state_nxt = S_ACCUM;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_ACCUM: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_DRAIN:  w_state_nxt = S_LATCH;
            S_LATCH:  w_state_nxt = S_RESULT;
            S_RESULT: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESULT;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        w_ab_ready  = 1'b0;
        w_mac_clr   = 1'b1;
        w_res_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE:   w_busy      = 1'b0;
            S_CLEAR:  w_mac_clr   = 1'b0;
            S_ACCUM:  w_ab_ready  = 1'b1;
            S_DRAIN:  w_busy      = 1'b1;
            S_LATCH:  w_busy      = 1'b1;
            S_RESULT: w_res_valid = 1'b1;
            default:  w_busy      = 1'b1;
        endcase
    end

    assign ab_ready  = w_ab_ready;
    assign mac_clr   = w_mac_clr;
    assign res_valid = w_res_valid;
    assign busy      = w_busy;

    // Length latch, element counter and operand pipeline; a_q/b_q return to 0 when nothing was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= 8'd0;
            r_cnt <= 8'd0;
            r_a_q <= 8'd0;
            r_b_q <= 8'd0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_len <= len;
            end
            if (r_state == S_CLEAR) begin
                r_cnt <= 8'd0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_nxt;
            end
            r_a_q <= w_accept ? a_data : 8'd0;
            r_b_q <= w_accept ? b_data : 8'd0;
        end
    end

    assign mac_in1 = r_a_q;
    assign mac_in2 = r_b_q;

`ifdef DOT_SEQ_SAT_EN
    sat_res_t w_clamp;
    logic     r_res_sat;

    assign w_clamp = sat_clamp($signed(mac_acc));

    // Result register, clamped to 16-bit signed range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_data <= 26'd0;
            r_res_sat  <= 1'b0;
        end else if (r_state == S_LATCH) begin
            r_res_data <= w_clamp.data;
            r_res_sat  <= w_clamp.sat;
        end
    end

    assign res_sat = r_res_sat;
`else
    // Result register, raw accumulator value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_data <= 26'd0;
        end else if (r_state == S_LATCH) begin
            r_res_data <= mac_acc;
        end
    end

    assign res_sat = 1'b0;
`endif

    assign res_data = r_res_data;

endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq with a behavioural MAC model wired as the sibling accumulator.
module tb_dot_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic signed [7:0]  a_data;
    logic signed [7:0]  b_data;
    logic               ab_valid;
    logic               ab_ready;
    logic signed [7:0]  mac_in1;
    logic signed [7:0]  mac_in2;
    logic               mac_clr;
    logic signed [25:0] mac_acc;
    logic signed [25:0] res_data;
    logic               res_valid;
    logic               res_ready;
    logic               res_sat;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [7:0]  va [0:7];
    logic signed [7:0]  vb [0:7];
    logic               g_tmo;
    logic               g_clr;
    logic signed [7:0]  g_in1;
    logic signed [7:0]  g_in2;

    // MAC model: clear when mac_clr=0, else accumulate in1*in2; pre_en lets the bench preload it.
    logic               pre_en = 1'b0;
    logic signed [25:0] pre_val = 26'sd0;
    logic signed [25:0] m_acc = 26'sd0;
    logic signed [25:0] m_prod;
    assign m_prod  = 26'(mac_in1) * 26'(mac_in2);
    assign mac_acc = m_acc;
    always @(posedge clk) begin
        if (pre_en)        m_acc <= pre_val;
        else if (!mac_clr) m_acc <= 26'sd0;
        else               m_acc <= m_acc + m_prod;
    end

    always #5 clk = ~clk;

    dot_seq dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .a_data(a_data), .b_data(b_data), .ab_valid(ab_valid), .ab_ready(ab_ready),
        .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_sat(res_sat), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_one(input logic signed [7:0] a, input logic signed [7:0] b);
        ab_valid = 1'b1;
        a_data   = a;
        b_data   = b;
        for (int i = 0; i < 50 && !ab_ready; i++) step();
        if (!ab_ready) g_tmo = 1'b1;
        step();
        ab_valid = 1'b0;
        a_data   = 8'sd0;
        b_data   = 8'sd0;
    endtask

    // Start a run, feed n_pairs from va/vb with gap idle cycles before each, measure cycles to res_valid.
    task automatic run_vec(input int n_len, input int n_pairs, input int gap, output int lat);
        g_tmo = 1'b0;
        start = 1'b1;
        len   = 8'(n_len);
        step();
        start = 1'b0;
        g_clr = mac_clr;
        for (int k = 0; k < n_pairs; k++) begin
            for (int g = 0; g < gap; g++) begin
                ab_valid = 1'b0;
                step();
            end
            feed_one(va[k], vb[k]);
        end
        g_in1 = mac_in1;
        g_in2 = mac_in2;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            if (res_valid) begin
                lat = c;
                break;
            end
            step();
        end
        if (g_tmo) lat = -1;
    endtask

    task automatic consume;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        n_total++; if (ab_ready !== 1'b0)  $display("FAIL rst_ab_ready got %0b want 0", ab_ready);  else n_pass++;
        n_total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %0b want 0", res_valid); else n_pass++;
        n_total++; if (res_sat !== 1'b0)   $display("FAIL rst_res_sat got %0b want 0", res_sat);     else n_pass++;
        n_total++; if (busy !== 1'b0)      $display("FAIL rst_busy got %0b want 0", busy);           else n_pass++;
        n_total++; if (mac_in1 !== 8'sd0)  $display("FAIL rst_mac_in1 got %0d want 0", mac_in1);     else n_pass++;
        n_total++; if (mac_in2 !== 8'sd0)  $display("FAIL rst_mac_in2 got %0d want 0", mac_in2);     else n_pass++;
        n_total++; if (mac_clr !== 1'b1)   $display("FAIL rst_mac_clr got %0b want 1", mac_clr);     else n_pass++;
        n_total++; if (res_data !== 26'sd0) $display("FAIL rst_res_data got %0d want 0", res_data);  else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic;
        int lat;
        va[0] = 8'sd2;  vb[0] = 8'sd3;
        va[1] = -8'sd4; vb[1] = 8'sd5;
        va[2] = 8'sd7;  vb[2] = 8'sd7;
        run_vec(3, 3, 0, lat);
        n_total++; if (g_clr !== 1'b0)      $display("FAIL basic_clear got mac_clr=%0b want 0", g_clr); else n_pass++;
        n_total++; if (g_in1 !== 8'sd7)     $display("FAIL basic_drain_in1 got %0d want 7", g_in1);    else n_pass++;
        n_total++; if (g_in2 !== 8'sd7)     $display("FAIL basic_drain_in2 got %0d want 7", g_in2);    else n_pass++;
        n_total++; if (lat !== 3)           $display("FAIL basic_latency got %0d want 3", lat);        else n_pass++;
        n_total++; if (res_data !== 26'sd35) $display("FAIL basic_data got %0d want 35", res_data);    else n_pass++;
        n_total++; if (res_sat !== 1'b0)    $display("FAIL basic_sat got %0b want 0", res_sat);        else n_pass++;
        consume();
        n_total++; if (busy !== 1'b0)       $display("FAIL basic_idle got busy=%0b want 0", busy);     else n_pass++;
    endtask

    task automatic test_len_zero;
        int lat;
        pre_en  = 1'b1;
        pre_val = 26'sd1234;
        step();
        pre_en  = 1'b0;
        run_vec(0, 0, 0, lat);
        n_total++; if (g_clr !== 1'b0)       $display("FAIL len0_clear got mac_clr=%0b want 0", g_clr); else n_pass++;
        n_total++; if (lat !== 4)            $display("FAIL len0_latency got %0d want 4", lat);         else n_pass++;
        n_total++; if (res_data !== 26'sd0)  $display("FAIL len0_data got %0d want 0", res_data);       else n_pass++;
        consume();
    endtask

    task automatic test_saturation;
        int lat;
        for (int k = 0; k < 4; k++) begin
            va[k] = 8'sd127;
            vb[k] = 8'sd127;
        end
        run_vec(4, 4, 0, lat);
        n_total++; if (lat !== 3) $display("FAIL sat_latency got %0d want 3", lat); else n_pass++;
`ifdef DOT_SEQ_SAT_EN
        n_total++; if (res_data !== 26'sd32767) $display("FAIL sat_data got %0d want 32767", res_data); else n_pass++;
        n_total++; if (res_sat !== 1'b1)        $display("FAIL sat_flag got %0b want 1", res_sat);       else n_pass++;
`else
        n_total++; if (res_data !== 26'sd64516) $display("FAIL sat_data got %0d want 64516", res_data); else n_pass++;
        n_total++; if (res_sat !== 1'b0)        $display("FAIL sat_flag got %0b want 0", res_sat);       else n_pass++;
`endif
        consume();
    endtask

    task automatic test_stall;
        int lat;
        va[0] = -8'sd128; vb[0] = -8'sd128;
        va[1] = -8'sd128; vb[1] = -8'sd128;
        run_vec(2, 2, 1, lat);
        n_total++; if (lat !== 3) $display("FAIL stall_latency got %0d want 3", lat); else n_pass++;
`ifdef DOT_SEQ_SAT_EN
        n_total++; if (res_data !== 26'sd32767) $display("FAIL stall_data got %0d want 32767", res_data); else n_pass++;
        n_total++; if (res_sat !== 1'b1)        $display("FAIL stall_sat got %0b want 1", res_sat);       else n_pass++;
`else
        n_total++; if (res_data !== 26'sd32768) $display("FAIL stall_data got %0d want 32768", res_data); else n_pass++;
        n_total++; if (res_sat !== 1'b0)        $display("FAIL stall_sat got %0b want 0", res_sat);       else n_pass++;
`endif
        consume();
    endtask

    task automatic test_hold;
        int lat;
        va[0] = 8'sd5; vb[0] = 8'sd6;
        run_vec(1, 1, 0, lat);
        n_total++; if (lat !== 3) $display("FAIL hold_latency got %0d want 3", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len   = 8'd9;
            step();
            n_total++; if (res_valid !== 1'b1)   $display("FAIL hold_valid cyc %0d got %0b want 1", i, res_valid); else n_pass++;
            n_total++; if (res_data !== 26'sd30) $display("FAIL hold_data cyc %0d got %0d want 30", i, res_data); else n_pass++;
        end
        start = 1'b0;
        consume();
        n_total++; if (busy !== 1'b0)      $display("FAIL hold_idle got busy=%0b want 0", busy);        else n_pass++;
        n_total++; if (res_valid !== 1'b0) $display("FAIL hold_drop got res_valid=%0b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_abort;
        int lat;
        start = 1'b1;
        len   = 8'd5;
        step();
        start = 1'b0;
        feed_one(8'sd1, 8'sd1);
        feed_one(8'sd2, 8'sd2);
        rst = 1'b1;
        step();
        n_total++; if (ab_ready !== 1'b0)   $display("FAIL abort_ab_ready got %0b want 0", ab_ready);   else n_pass++;
        n_total++; if (busy !== 1'b0)       $display("FAIL abort_busy got %0b want 0", busy);           else n_pass++;
        n_total++; if (res_valid !== 1'b0)  $display("FAIL abort_res_valid got %0b want 0", res_valid); else n_pass++;
        n_total++; if (mac_in1 !== 8'sd0)   $display("FAIL abort_mac_in1 got %0d want 0", mac_in1);     else n_pass++;
        n_total++; if (mac_clr !== 1'b1)    $display("FAIL abort_mac_clr got %0b want 1", mac_clr);     else n_pass++;
        n_total++; if (res_data !== 26'sd0) $display("FAIL abort_res_data got %0d want 0", res_data);   else n_pass++;
        rst = 1'b0;
        step();
        va[0] = 8'sd3; vb[0] = -8'sd3;
        run_vec(1, 1, 0, lat);
        n_total++; if (lat !== 3)            $display("FAIL abort_rerun_latency got %0d want 3", lat);  else n_pass++;
        n_total++; if (res_data !== -26'sd9) $display("FAIL abort_rerun_data got %0d want -9", res_data); else n_pass++;
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        a_data    = 8'sd0;
        b_data    = 8'sd0;
        ab_valid  = 1'b0;
        res_ready = 1'b0;
        g_tmo     = 1'b0;
        g_clr     = 1'b1;
        g_in1     = 8'sd0;
        g_in2     = 8'sd0;
        test_reset();
        test_basic();
        test_len_zero();
        test_saturation();
        test_stall();
        test_hold();
        test_abort();
        test_basic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 dot_seq SHALL use one clock `clk` and a synchronous, active-high reset `rst`.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  begin a dot product; sampled in IDLE only.
REQ-005 len  input  8  vector length, unsigned 0..255; sampled with start.
REQ-006 a_data  input  8  signed operand A element.
REQ-007 b_data  input  8  signed operand B element.
REQ-008 ab_valid  input  1  a_data/b_data pair valid.
REQ-009 ab_ready  output  1  pair accepted when ab_valid && ab_ready.
REQ-010 mac_in1  output  8  signed operand to MAC in1.
REQ-011 mac_in2  output  8  signed operand to MAC in2.
REQ-012 mac_clr  output  1  MAC control: 1 = accumulate, 0 = clear to zero next edge.
REQ-013 mac_acc  input  26  signed MAC accumulator value.
REQ-014 res_data  output  26  signed dot-product result.
REQ-015 res_valid  output  1  res_data valid.
REQ-016 res_ready  input  1  consumer accepts result when res_valid && res_ready.
REQ-017 res_sat  output  1  result was clamped (see Configuration).
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, ACCUM, DRAIN, LATCH and RESULT.
REQ-020 IDLE: on start, latch len, go to CLEAR; start is ignored in all other states.
REQ-021 CLEAR: mac_clr=0 for exactly one cycle; next state is ACCUM if the latched len is nonzero, else DRAIN.
REQ-022 ACCUM: ab_ready=1; each accepted pair is registered into a_q/b_q, and the element counter increments.
REQ-023 ACCUM: accepting element number len (the last one) SHALL go to DRAIN and drop ab_ready in the next cycle.
REQ-024 mac_in1/mac_in2 SHALL equal a_q/b_q during the cycle after an accept and 0 in every other cycle; mac_clr=1 in all states except CLEAR.
REQ-025 DRAIN: one cycle, during which the last product sits on the MAC inputs.
REQ-026 LATCH: one cycle; the result register is loaded from mac_acc, then go to RESULT.
REQ-027 RESULT: res_valid=1 with res_data held stable until res_ready; on handshake go to IDLE.
REQ-028 ab_ready SHALL be 0 outside ACCUM.
REQ-029 res_valid SHALL rise exactly 3 cycles after the last pair handshake.
REQ-030 ab_valid low in ACCUM SHALL stall without counter change; the MAC holds because it adds 0*0.
REQ-031 res_ready outside RESULT SHALL be ignored; a new start is accepted no earlier than the cycle after the result handshake.
REQ-032 The counter is 8-bit and SHALL never wrap, because the FSM exits at count==len.

Reset
REQ-033 rst SHALL force state IDLE, counter 0, a_q/b_q 0, and result register 0.
REQ-034 After rst: ab_ready=0, res_valid=0, res_sat=0, busy=0, mac_in1=mac_in2=0, mac_clr=1.
REQ-035 rst in any state, including mid-ACCUM, SHALL abort without emitting a result; the next start clears the MAC via CLEAR.

Configuration
REQ-036 Macro DOT_SEQ_SAT_EN defined: the LATCH value SHALL be clamped to the signed 16-bit range [-32768, 32767], sign-extended to 26 bits, with res_sat=1 when clamping occurred.
REQ-037 DOT_SEQ_SAT_EN undefined: res_data SHALL equal mac_acc unmodified, and res_sat SHALL be tied 0.

Structure
REQ-038 Package dot_seq_pkg SHALL hold: the state enum, DATA_W=8, ACC_W=26, LEN_W=8, SAT_MAX=32767 and SAT_MIN=-32768.
REQ-039 dot_seq SHALL contain no sub-module; the existing mac instance is a sibling connected at the parent level.

Verification
REQ-040 len=3, pairs (2,3), (-4,5), (7,7) with ab_valid continuous: res_data=35, res_valid 3 cycles after the third accept.
REQ-041 start with len=0 and a nonzero preloaded MAC: the FSM passes CLEAR, DRAIN, LATCH, and res_data=0.
REQ-042 len=4 of (127,127): res_data=32767 and res_sat=1 with DOT_SEQ_SAT_EN; res_data=64516 and res_sat=0 without it.
REQ-043 len=2, ab_valid high only on odd cycles, pairs (-128,-128)x2: result 32768 (unclamped) and the counter stalls correctly.
REQ-044 res_ready held low 5 cycles in RESULT: res_data/res_valid stable; start pulses are ignored until IDLE.
REQ-045 rst asserted after 2 of 5 accepts: all outputs take their reset values next cycle; a following len=1, (3,-3) run gives -9.
